// File: rtl/cp_inserter.sv
// ---------------------------------------------------------------------------
// cp_inserter
//
// TX-side OFDM cyclic-prefix inserter. It sits after the IFFT. It buffers one
// OFDM symbol of N complex samples, then emits the last L samples (cyclic
// prefix) followed by all N samples.
//
// Symbol size N comes from the 5G NR numerology: 0..4 -> 256..4096, 5..7 -> 256.
// Normal CP length is L = N*9/128. This is exact for every supported N.
//
// Optional build macro EXT_CP_EN:
//   Adds an ext_cp input. When ext_cp=1 and numerology==2, the extended CP
//   L = N/4 is used instead.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   numerology[2:0]  NR numerology, latched on the first accepted sample
//   ext_cp           (EXT_CP_EN only) extended-CP request, latched with numerology
//   in_data/valid    IFFT sample stream in, in_ready back-pressure
//   out_data/valid   CP + symbol stream out, out_ready back-pressure
//   out_sop          first CP word of a symbol
//   out_eop          last body word of a symbol
//   busy             from first accepted input sample until the eop handshake
// ---------------------------------------------------------------------------
module cp_inserter #(
    parameter int DATA_W    = 32,
    parameter int MAX_LOG2N = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        numerology,
`ifdef EXT_CP_EN
    input  logic              ext_cp,
`endif
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy
);

    localparam int AW    = MAX_LOG2N;
    localparam int LW    = MAX_LOG2N + 1;
    localparam int DEPTH = 1 << MAX_LOG2N;

    localparam logic [AW-1:0] A_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] L_ONE = {{(LW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        PRIME    = 2'd1,
        CP_OUT   = 2'd2,
        BODY_OUT = 2'd3
    } state_t;

    // Symbol length from numerology. Unsupported codes fall back to 256.
    function automatic logic [LW-1:0] sym_len_f(input logic [2:0] num);
        logic [3:0] sh_v;
        case (num)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4: sh_v = 4'd8 + {1'b0, num};
            default:                      sh_v = 4'd8;
        endcase
        return L_ONE << sh_v;
    endfunction

    // CP length. N is a multiple of 128, so N*9>>7 == (N>>7)*9 exactly.
    function automatic logic [LW-1:0] cp_len_f(input logic [LW-1:0] n, input logic ext);
        logic [LW-1:0] l_v;
        if (ext) begin
            l_v = n >> 2;
        end else begin
            l_v = (n >> 7) + ((n >> 7) << 3);
        end
        return l_v;
    endfunction

    state_t            state_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_addr_r;
    logic [AW-1:0]     rd_addr_r;
    logic [LW-1:0]     n_len_r;
    logic [LW-1:0]     cp_len_r;
    logic [LW-1:0]     rd_left_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;
    logic              rd_sop_r;
    logic              rd_eop_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              out_sop_r;
    logic              out_eop_r;
    logic              busy_r;
    logic [DATA_W-1:0] out_data_r;

    logic              in_fire_s;
    logic              adv_s;
    logic              issue_s;
    logic              last_in_s;
    logic              eop_fire_s;
    logic              ext_s;
    logic [AW-1:0]     n_mask_s;
    logic [LW-1:0]     cur_n_s;
    logic [LW-1:0]     cur_l_s;

`ifdef EXT_CP_EN
    // Extended CP only applies to numerology 2.
    always_comb begin
        ext_s = ext_cp && (numerology == 3'd2);
    end
`else
    // Normal CP only in this build.
    always_comb begin
        ext_s = 1'b0;
    end
`endif

    // Handshake qualifiers and read-side control.
    // The RAM read register and the output register form a two-stage pipe.
    // Both stages advance together whenever the output stage is empty or is
    // being accepted.
    always_comb begin
        in_fire_s  = in_valid && in_ready_r;
        adv_s      = !out_valid_r || out_ready;
        issue_s    = adv_s && (state_r != FILL) && (rd_left_r != {LW{1'b0}});
        n_mask_s   = n_len_r[AW-1:0] - A_ONE;
        last_in_s  = in_fire_s && (wr_addr_r != {AW{1'b0}}) && (wr_addr_r == n_mask_s);
        eop_fire_s = out_valid_r && out_ready && out_eop_r;
        cur_n_s    = sym_len_f(numerology);
        cur_l_s    = cp_len_f(cur_n_s, ext_s);
    end

    // Sample buffer write port.
    always_ff @(posedge clk) begin
        if (in_fire_s) begin
            mem_r[wr_addr_r] <= in_data;
        end
    end

    // Sample buffer synchronous read port. It only reads when the pipe advances.
    always_ff @(posedge clk) begin
        if (issue_s) begin
            rd_data_r <= mem_r[rd_addr_r];
        end
    end

    // Control FSM, read address generator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= FILL;
            wr_addr_r   <= {AW{1'b0}};
            rd_addr_r   <= {AW{1'b0}};
            n_len_r     <= {LW{1'b0}};
            cp_len_r    <= {LW{1'b0}};
            rd_left_r   <= {LW{1'b0}};
            rd_valid_r  <= 1'b0;
            rd_sop_r    <= 1'b0;
            rd_eop_r    <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_sop_r   <= 1'b0;
            out_eop_r   <= 1'b0;
            busy_r      <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
        end else begin
            if (adv_s) begin
                rd_valid_r  <= issue_s;
                rd_sop_r    <= issue_s && (state_r == PRIME);
                rd_eop_r    <= issue_s && (rd_left_r == L_ONE);
                out_valid_r <= rd_valid_r;
                out_sop_r   <= rd_valid_r && rd_sop_r;
                out_eop_r   <= rd_valid_r && rd_eop_r;
                out_data_r  <= rd_valid_r ? rd_data_r : {DATA_W{1'b0}};
            end

            // The buffer is read circularly from N-L for N+L words.
            // N is a power of two, so masking the address wraps it into the body.
            if (issue_s) begin
                rd_addr_r <= (rd_addr_r + A_ONE) & n_mask_s;
                rd_left_r <= rd_left_r - L_ONE;
            end

            case (state_r)
                FILL: begin
                    if (in_fire_s) begin
                        wr_addr_r <= wr_addr_r + A_ONE;
                        if (wr_addr_r == {AW{1'b0}}) begin
                            n_len_r  <= cur_n_s;
                            cp_len_r <= cur_l_s;
                            busy_r   <= 1'b1;
                        end
                        if (last_in_s) begin
                            state_r    <= PRIME;
                            in_ready_r <= 1'b0;
                            wr_addr_r  <= {AW{1'b0}};
                            rd_addr_r  <= n_len_r[AW-1:0] - cp_len_r[AW-1:0];
                            rd_left_r  <= n_len_r + cp_len_r;
                        end
                    end
                end
                PRIME: begin
                    state_r <= CP_OUT;
                end
                CP_OUT: begin
                    // The last CP read is issued when N+1 reads remain.
                    if (issue_s && (rd_left_r == n_len_r + L_ONE)) begin
                        state_r <= BODY_OUT;
                    end
                end
                BODY_OUT: begin
                    if (eop_fire_s) begin
                        state_r    <= FILL;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                end
                default: begin
                    state_r <= FILL;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_sop   = out_sop_r;
    assign out_eop   = out_eop_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_cp_inserter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_cp_inserter
//
// Randomised bench for cp_inserter. The reference model builds each expected
// symbol straight from the input array: input[N-L..N-1] followed by
// input[0..N-1], with sop on the first word and eop on the last word.
// ---------------------------------------------------------------------------
module tb_cp_inserter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  numerology = 3'd0;
`ifdef EXT_CP_EN
    logic        ext_cp = 1'b0;
`endif
    logic [31:0] in_data = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sop;
    logic        out_eop;
    logic        busy;

    cp_inserter #(.DATA_W(32), .MAX_LOG2N(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .numerology (numerology),
`ifdef EXT_CP_EN
        .ext_cp     (ext_cp),
`endif
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [31:0] d;
    } exp_t;

    exp_t        exp_q[$];
    int          len_q[$];
    logic [31:0] sym_d [0:4095];

    int checks = 0;
    int failures = 0;
    bit ready_mode = 1'b0;

    // Monitor state.
    int          cyc = 0;
    int          words = 0;
    int          hs_cyc = 0;
    int          in_low = 0;
    int          last_len = 0;
    bit          prev_hold = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_in_ready = 1'b1;
    bit          after_eop = 1'b0;
    bit          stall_seen = 1'b0;
    logic [33:0] hold_w = 34'd0;
    exp_t        e;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive out_ready: either held high, or toggled at random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor and scoreboard. It samples on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            words = 0;
            in_low = 0;
            prev_hold = 1'b0;
            prev_valid = 1'b0;
            prev_in_ready = 1'b1;
            after_eop = 1'b0;
        end else begin
            if (after_eop) begin
                check_eq("post_eop_state", {in_ready, out_valid, busy}, {1'b1, 1'b0, 1'b0});
                after_eop = 1'b0;
            end
            if (prev_hold) begin
                check_eq("stall_hold", {out_valid, out_sop, out_eop, out_data}, {1'b1, hold_w});
            end
            prev_hold = out_valid && !out_ready;
            hold_w = {out_sop, out_eop, out_data};
            // The Nth input handshake is seen one negedge before its edge.
            // out_valid rises two edges later, so it is seen three negedges on.
            if (out_valid && !prev_valid) begin
                check_eq("first_valid_latency", cyc - hs_cyc, 3);
                stall_seen = 1'b0;
            end
            if (out_valid && !out_ready) stall_seen = 1'b1;
            prev_valid = out_valid;
            if (in_valid && in_ready) hs_cyc = cyc;
            if (!in_ready) begin
                in_low++;
            end else if (!prev_in_ready) begin
                if (!stall_seen) check_eq("in_ready_low_len", in_low, last_len + 2);
                in_low = 0;
            end
            prev_in_ready = in_ready;
            if (out_valid && out_ready) begin
                if (out_sop) begin
                    words = 0;
                    check_eq("busy_at_sop", busy, 1'b1);
                end
                words++;
                if (exp_q.size() == 0) begin
                    check_eq("exp_avail", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("word", {out_sop, out_eop, out_data}, {e.sop, e.eop, e.d});
                end
                if (out_eop) begin
                    after_eop = 1'b1;
                    last_len = words;
                    if (len_q.size() != 0) check_eq("sym_words", words, len_q.pop_front());
                    words = 0;
                end
            end
        end
    end

    // Feed one symbol, then queue its expected CP + body output.
    task automatic send_symbol(input int num_first, input int num_later, input bit ext, input bit ramp);
        int n;
        int l;
        int i;
        int budget;
        bit acc;
        exp_t x;
        n = (num_first <= 4) ? (256 << num_first) : 256;
        l = (ext && num_first == 2) ? n / 4 : (n * 9) / 128;
        for (int k = 0; k < n; k++) sym_d[k] = ramp ? 32'(k) : $urandom;
        numerology = 3'(num_first);
`ifdef EXT_CP_EN
        ext_cp = ext;
`endif
        i = 0;
        budget = 0;
        while (i < n && budget < 30000) begin
            in_valid = 1'b1;
            in_data = sym_d[i];
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget++;
            if (acc) i++;
            if (i == 10) numerology = 3'(num_later);
        end
        in_valid = 1'b0;
        check_eq("in_accept_count", i, n);
        for (int k = 0; k < n + l; k++) begin
            x.d = (k < l) ? sym_d[n - l + k] : sym_d[k - l];
            x.sop = (k == 0);
            x.eop = (k == n + l - 1);
            exp_q.push_back(x);
        end
        len_q.push_back(n + l);
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((exp_q.size() != 0 || !in_ready) && b < 40000) begin
            @(posedge clk);
            #1;
            b++;
        end
        check_eq("idle_drain", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq(tag, {in_ready, out_valid, out_sop, out_eop, busy, out_data},
                 {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
    endtask

    initial begin
        int b;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp, numerology 0, then random numerology 4, out_ready high.
        send_symbol(0, 0, 1'b0, 1'b1);
        send_symbol(4, 4, 1'b0, 1'b0);
        wait_idle();

        // Numerology 1 with 50% random back-pressure.
        ready_mode = 1'b1;
        send_symbol(1, 1, 1'b0, 1'b0);
        wait_idle();
        ready_mode = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back: numerology changes to 3 during the first symbol.
        send_symbol(0, 3, 1'b0, 1'b0);
        send_symbol(3, 3, 1'b0, 1'b0);
        // An out-of-range numerology maps to 256.
        send_symbol(6, 6, 1'b0, 1'b0);
        wait_idle();

        // Reset during output word 100 of a ramp symbol.
        send_symbol(0, 0, 1'b0, 1'b1);
        b = 0;
        while (words < 100 && b < 2000) begin
            @(posedge clk);
            #1;
            b++;
        end
        check_eq("reset_reach_word100", words >= 100, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midsym_reset");
        exp_q.delete();
        len_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_symbol(0, 0, 1'b0, 1'b1);
        wait_idle();

`ifdef EXT_CP_EN
        send_symbol(2, 2, 1'b1, 1'b0);
        send_symbol(0, 0, 1'b1, 1'b0);
        wait_idle();
`endif

        repeat (4) @(posedge clk);
        #1;
        check_eq("final_idle", {in_ready, out_valid, busy}, {1'b1, 1'b0, 1'b0});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
